// File: rtl/video_timing_pkg.sv
// Shared video timing constants for the sync generator and the mode sequencer.
// The frame-end coordinates live here only, so both blocks always agree.
package video_timing_pkg;

  localparam logic [1:0] MODE_48K  = 2'b00;
  localparam logic [1:0] MODE_128K = 2'b01;
  localparam logic [1:0] MODE_PENT = 2'b10;

  localparam logic [8:0] END_H_48K  = 9'd447;
  localparam logic [8:0] END_V_48K  = 9'd311;
  localparam logic [8:0] END_H_128K = 9'd455;
  localparam logic [8:0] END_V_128K = 9'd310;
  localparam logic [8:0] END_H_PENT = 9'd447;
  localparam logic [8:0] END_V_PENT = 9'd319;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WAIT_FRAME = 2'd1;
  localparam state_t ST_APPLY      = 2'd2;
  localparam state_t ST_SETTLE     = 2'd3;

  // Encoding 11 has no timing of its own; it behaves as Pentagon everywhere.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_PENT : m;
  endfunction

endpackage

// File: rtl/video_frame_end_detect.sv
// Flags the last pixel of a frame for the mode currently in effect.
module video_frame_end_detect
  import video_timing_pkg::*;
(
  input  logic [1:0] cur_mode,
  input  logic [8:0] hcnt,
  input  logic [8:0] vcnt,
  output logic       frame_end
);

  // Compare the generator position against the end coordinates of cur_mode.
  always_comb begin
    frame_end = 1'b0;
    case (cur_mode)
      MODE_128K:       frame_end = (hcnt == END_H_128K) && (vcnt == END_V_128K);
      MODE_PENT, 2'b11: frame_end = (hcnt == END_H_PENT) && (vcnt == END_V_PENT);
      default:         frame_end = (hcnt == END_H_48K) && (vcnt == END_V_48K);
    endcase
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// Defers video mode requests to a frame boundary, strobes the generator with
// the new mode, then keeps video muted for a few frames while the monitor relocks.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | no change in progress, outputs quiet
//   WAIT_FRAME  | change pending, waiting for frame end or timeout
//   APPLY       | one cycle: mode_changed strobe, new mode driven
//   SETTLE      | video muted, counting frames of the new mode
module video_mode_sequencer
  import video_timing_pkg::*;
#(
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned WAIT_TIMEOUT  = 262143
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  input  logic [8:0] hcnt,
  input  logic [8:0] vcnt,
  output logic       mode_changed,
  output logic [1:0] mode,
  output logic       busy,
  output logic       video_mute,
  output logic [1:0] cur_mode
);

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_FRAMES);
  localparam logic [17:0] WAIT_LAST   = 18'(WAIT_TIMEOUT - 1);

  state_t      state;
  state_t      nxt;
  logic [1:0]  pending;
  logic [1:0]  pend_nxt;
  logic [1:0]  req_norm;
  logic [3:0]  settle_cnt;
  logic [17:0] wait_cnt;
  logic        frame_end;
  logic        timeout;

  video_frame_end_detect u_frame_end (
    .cur_mode  (cur_mode),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .frame_end (frame_end)
  );

  // The strobe is a decode of the state register; it is held off while rst is
  // asserted so the re-sync pulse lands in the first cycle after release.
  assign mode_changed = (state == ST_APPLY) && !rst;

  // Next-state decode; a new request always replaces the pending one.
  always_comb begin
    req_norm = norm_mode(req_mode);
    pend_nxt = req_valid ? req_norm : pending;
    timeout  = (wait_cnt >= WAIT_LAST);
    nxt      = state;
    case (state)
      ST_IDLE: begin
        if (req_valid && (req_norm != cur_mode)) nxt = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (req_valid && (req_norm == cur_mode)) nxt = ST_IDLE;
        else if (frame_end || timeout)           nxt = ST_APPLY;
      end
      ST_APPLY: nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (frame_end && (settle_cnt <= 4'd1))
          nxt = (pend_nxt != cur_mode) ? ST_WAIT_FRAME : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_APPLY;
      pending    <= MODE_48K;
      mode       <= MODE_48K;
      cur_mode   <= MODE_48K;
      busy       <= 1'b1;
      video_mute <= 1'b1;
      settle_cnt <= 4'd0;
      wait_cnt   <= 18'd0;
    end else begin
      state   <= nxt;
      pending <= pend_nxt;
      busy    <= (nxt != ST_IDLE);

      if ((state == ST_WAIT_FRAME) && (nxt == ST_WAIT_FRAME))
        wait_cnt <= (wait_cnt == '1) ? wait_cnt : wait_cnt + 18'd1;
      else
        wait_cnt <= 18'd0;

      // mode only moves on entry to APPLY, so the generator sees it stable otherwise.
      if (nxt == ST_APPLY) begin
        mode       <= pend_nxt;
        video_mute <= 1'b1;
      end

      if (state == ST_APPLY) begin
        cur_mode   <= mode;
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == ST_SETTLE) && frame_end) begin
        settle_cnt <= settle_cnt - 4'd1;
        if (settle_cnt <= 4'd1) video_mute <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed bench for the video mode sequencer. Expected strobe modes are queued
// when a request is driven and checked by a monitor when mode_changed fires.
module tb_video_mode_sequencer;

  localparam int TO = 40;
  localparam int SF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_mode = 2'b00;
  logic [8:0] hcnt = 9'd0;
  logic [8:0] vcnt = 9'd0;
  logic       mode_changed;
  logic [1:0] mode;
  logic       busy;
  logic       video_mute;
  logic [1:0] cur_mode;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_mode;
  logic       prev_mc = 1'b0;
  int         n;

  always #5 clk = ~clk;

  video_mode_sequencer #(
    .SETTLE_FRAMES (SF),
    .WAIT_TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_mode     (req_mode),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .mode_changed (mode_changed),
    .mode         (mode),
    .busy         (busy),
    .video_mute   (video_mute),
    .cur_mode     (cur_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_n(input int cnt);
    for (int i = 0; i < cnt; i++) cyc();
  endtask

  // One cycle at the given position, then back to the origin.
  task automatic frame(input logic [8:0] h, input logic [8:0] v);
    cyc();
    hcnt = h;
    vcnt = v;
    cyc();
    hcnt = 9'd0;
    vcnt = 9'd0;
  endtask

  task automatic req(input logic [1:0] m);
    cyc();
    req_valid = 1'b1;
    req_mode  = m;
    cyc();
    req_valid = 1'b0;
  endtask

  // Scoreboard side: every strobe must match the oldest queued mode.
  always @(negedge clk) begin
    if (mode_changed === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("FAIL strobe_unexpected observed mode=%0d expected no strobe", mode);
      end
      if (exp_q.size() > 0) begin
        exp_mode = exp_q.pop_front();
        checks++;
        assert (mode === exp_mode)
        else begin
          errors++;
          $error("FAIL strobe_mode observed=%0d expected=%0d", mode, exp_mode);
        end
      end
      checks++;
      assert (prev_mc !== 1'b1)
      else begin
        errors++;
        $error("FAIL strobe_back_to_back observed=1 expected=0");
      end
    end
    prev_mc <= mode_changed;
  end

  initial begin
    // Reset values.
    rst = 1'b1;
    idle_n(3);
    chk("rst_strobe", mode_changed, 0);
    chk("rst_busy", busy, 1);
    chk("rst_mute", video_mute, 1);
    chk("rst_mode", mode, 0);
    chk("rst_cur_mode", cur_mode, 0);

    // Release: 48K re-sync strobe, then two 48K frames of mute.
    exp_q.push_back(2'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rel_strobe", mode_changed, 1);
    chk("rel_mode", mode, 0);
    cyc();
    chk("rel_strobe_single", mode_changed, 0);
    chk("rel_mute_settle", video_mute, 1);
    frame(9'd455, 9'd310);
    chk("rel_wrong_end_ignored", video_mute, 1);
    frame(9'd447, 9'd311);
    chk("rel_mute_after_1", video_mute, 1);
    frame(9'd447, 9'd311);
    chk("rel_mute_after_2", video_mute, 0);
    chk("rel_idle", busy, 0);

    // 48K -> 128K deferred to the 48K frame end.
    exp_q.push_back(2'd1);
    cyc();
    hcnt = 9'd10;
    vcnt = 9'd0;
    req_valid = 1'b1;
    req_mode = 2'd1;
    cyc();
    req_valid = 1'b0;
    hcnt = 9'd0;
    chk("t2_busy_wait", busy, 1);
    chk("t2_mute_wait", video_mute, 0);
    idle_n(5);
    frame(9'd447, 9'd310);
    chk("t2_no_early_strobe", mode_changed, 0);
    frame(9'd447, 9'd311);
    chk("t2_strobe", mode_changed, 1);
    chk("t2_mode", mode, 1);
    chk("t2_mute_apply", video_mute, 1);
    chk("t2_cur_mode_apply", cur_mode, 0);
    cyc();
    chk("t2_cur_mode", cur_mode, 1);
    frame(9'd447, 9'd311);
    chk("t2_old_end_ignored", video_mute, 1);
    frame(9'd455, 9'd310);
    frame(9'd455, 9'd310);
    chk("t2_mute_done", video_mute, 0);
    chk("t2_idle", busy, 0);
    chk("t2_mode_held", mode, 1);

    // Request 11 from 128K becomes Pentagon.
    exp_q.push_back(2'd2);
    req(2'd3);
    chk("t3_busy", busy, 1);
    frame(9'd455, 9'd310);
    chk("t3_strobe", mode_changed, 1);
    frame(9'd447, 9'd319);
    frame(9'd447, 9'd319);
    chk("t3_idle", busy, 0);
    chk("t3_cur_mode", cur_mode, 2);
    // Requests equal to Pentagon are ignored.
    req(2'd3);
    chk("t3_ign11_busy", busy, 0);
    req(2'd2);
    chk("t3_ign10_busy", busy, 0);

    // Last request wins in WAIT_FRAME.
    req(2'd0);
    chk("t4_busy", busy, 1);
    exp_q.push_back(2'd1);
    req(2'd1);
    frame(9'd447, 9'd319);
    chk("t4_strobe", mode_changed, 1);
    chk("t4_mode", mode, 1);
    // Request during SETTLE is applied after settling.
    cyc();
    exp_q.push_back(2'd0);
    req(2'd0);
    chk("t4_mute_settle", video_mute, 1);
    frame(9'd455, 9'd310);
    frame(9'd455, 9'd310);
    chk("t4_unmuted_wait", video_mute, 0);
    chk("t4_busy_wait", busy, 1);
    frame(9'd455, 9'd310);
    chk("t4_second_strobe", mode_changed, 1);
    chk("t4_second_mode", mode, 0);
    frame(9'd447, 9'd311);
    frame(9'd447, 9'd311);
    chk("t4_idle", busy, 0);

    // Frame end and a new request in the same cycle: the new one is applied.
    req(2'd1);
    chk("t4b_busy", busy, 1);
    exp_q.push_back(2'd2);
    cyc();
    hcnt = 9'd447;
    vcnt = 9'd311;
    req_valid = 1'b1;
    req_mode = 2'd3;
    cyc();
    req_valid = 1'b0;
    hcnt = 9'd0;
    vcnt = 9'd0;
    chk("t4b_strobe", mode_changed, 1);
    chk("t4b_mode", mode, 2);
    frame(9'd447, 9'd319);
    frame(9'd447, 9'd319);
    chk("t4b_idle", busy, 0);
    chk("t4b_cur_mode", cur_mode, 2);

    // A request back to cur_mode cancels the wait.
    req(2'd0);
    chk("t4c_busy", busy, 1);
    req(2'd2);
    chk("t4c_cancel", busy, 0);
    frame(9'd447, 9'd319);
    chk("t4c_still_idle", busy, 0);

    // Frozen counters: forced apply after exactly TO cycles in WAIT_FRAME.
    exp_q.push_back(2'd1);
    cyc();
    req_valid = 1'b1;
    req_mode = 2'd1;
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (mode_changed !== 1'b1 && n < 4 * TO) begin
      cyc();
      n++;
    end
    chk("t5_timeout_cycles", n, TO);
    chk("t5_mode", mode, 1);

    // Reset in SETTLE drops the pending request and re-syncs to 48K.
    cyc();
    req(2'd2);
    chk("t6_settle_busy", busy, 1);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk("t6_rst_no_strobe", mode_changed, 0);
    chk("t6_rst_cur_mode", cur_mode, 0);
    chk("t6_rst_mute", video_mute, 1);
    exp_q.push_back(2'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_strobe", mode_changed, 1);
    chk("t6_mode", mode, 0);
    cyc();
    chk("t6_cur_mode", cur_mode, 0);
    frame(9'd447, 9'd311);
    frame(9'd447, 9'd311);
    chk("t6_pending_dropped", busy, 0);
    chk("t6_unmuted", video_mute, 0);

    idle_n(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
